// File: rtl/ysyx_22040088_inst_fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Holds the fetch FSM state encoding and the default widths and reset PC.
package ysyx_22040088_inst_fetch_pkg;

  localparam int unsigned XLEN_DEF     = 64;
  localparam int unsigned ILEN_DEF     = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  // Where the FSM goes once the current fetch is finished with.
  function automatic fetch_state_e resume_state(input logic halt);
    return halt ? S_IDLE : S_REQ;
  endfunction

endpackage

// File: rtl/ysyx_22040088_fetch_buf.sv
// Single-entry valid/ready buffer between the fetch FSM and the decoder.
// can_push_o tells the FSM the entry is empty or being drained this cycle.
module ysyx_22040088_fetch_buf #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned ILEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            flush_i,
  input  logic [ILEN-1:0] data_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [ILEN-1:0] data_o,
  output logic [XLEN-1:0] pc_o,
  output logic            can_push_o
);

  logic            valid_q, valid_d;
  logic [ILEN-1:0] data_q, data_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // Flush wins over a push so a redirect never lets stale data through.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (push_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign pc_o       = pc_q;
  assign can_push_o = !valid_q || ready_i;

endmodule

// File: rtl/ysyx_22040088_inst_fetch.sv
// Fetch stage: owns the PC, issues one imem read at a time and hands
// fetched instructions to decode through a single-entry buffer.
module ysyx_22040088_inst_fetch
  import ysyx_22040088_inst_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     ILEN     = ILEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_addr_q, req_addr_d;
  logic            drop_q, drop_d;

  logic            buf_push;
  logic            buf_flush;
  logic            buf_can_push;
  logic [XLEN-1:0] redirect_target;

  assign redirect_target = redirect_pc & ~XLEN'(3);

  // A request only goes out when its response is guaranteed a free buffer
  // slot; once raised it stays up because nothing refills the buffer meanwhile.
  assign imem_req_valid = (state_q == S_REQ) && buf_can_push;
  assign imem_req_addr  = req_addr_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    buf_push  = 1'b0;
    buf_flush = redirect_valid;

    case (state_q)
      S_IDLE: begin
        if (!halt) state_d = S_REQ;
      end
      S_REQ: begin
        if (imem_req_valid) begin
          if (imem_req_ready) state_d = S_WAIT;
          if (redirect_valid) drop_d = 1'b1;
        end else if (redirect_valid) begin
          state_d = resume_state(halt);
        end else begin
          state_d = halt ? S_IDLE : S_HOLD;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          drop_d  = 1'b0;
          state_d = resume_state(halt);
          if (!drop_q && !redirect_valid) begin
            buf_push = 1'b1;
            pc_d     = pc_q + XLEN'(4);
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid || buf_can_push) state_d = resume_state(halt);
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) pc_d = redirect_target;
  end

  // A pending request keeps its address even if the PC is redirected under it.
  assign req_addr_d = (imem_req_valid && !imem_req_ready) ? req_addr_q : pc_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      drop_q     <= drop_d;
    end
  end

  ysyx_22040088_fetch_buf #(
    .XLEN (XLEN),
    .ILEN (ILEN)
  ) u_fetch_buf (
    .clk        (clk),
    .rst_n      (rst),
    .push_i     (buf_push),
    .flush_i    (buf_flush),
    .data_i     (imem_rsp_data),
    .pc_i       (pc_q),
    .valid_o    (inst_valid),
    .ready_i    (inst_ready),
    .data_o     (inst),
    .pc_o       (inst_pc),
    .can_push_o (buf_can_push)
  );

endmodule

// File: tb/tb_ysyx_22040088_inst_fetch.sv
// Randomized bench for the fetch stage: a stream model of expected PCs
// fed by a segment queue (reset / redirect targets) checked by a monitor.
module tb_ysyx_22040088_inst_fetch;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc    = '0;
  logic        halt           = 1'b0;
  logic        inst_valid;
  logic        inst_ready     = 1'b1;
  logic [31:0] inst;
  logic [63:0] inst_pc;

  always #5 clk = ~clk;

  ysyx_22040088_inst_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Expected stream starting points: pushed on reset and on every redirect.
  logic [63:0] seg_q[$];

  // Memory model state (driver side) and acceptance seen by the monitor.
  logic        acc_seen = 1'b0;
  logic [63:0] acc_addr = '0;
  logic        outstanding = 1'b0;
  int          lat_left = 0;
  logic [63:0] rsp_addr = '0;
  logic        zw = 1'b0;

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return (a[31:0] * 32'd3) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] pick_target();
    logic [63:0] t;
    case ($urandom_range(0, 3))
      0: t = 64'h8000_1002;
      1: t = {32'h0, $urandom()};
      2: t = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      default: t = RESET_PC + 64'($urandom_range(0, 255));
    endcase
    return t;
  endfunction

  // One clock of stimulus; percentages control how often each input fires.
  task automatic step(input int rdy_pct, input int lat_max, input int ir_pct,
                      input int redir_pct, input int halt_pct, input int spur_pct,
                      input int rst_pct, input logic force_en, input logic [63:0] force_tgt);
    logic [63:0] tgt;
    @(posedge clk);
    #1;
    if (!rst) begin
      rst = 1'b1;
    end else if (int'($urandom_range(0, 99)) < rst_pct) begin
      rst = 1'b0;
      seg_q.push_back(RESET_PC);
    end
    if (acc_seen) begin
      outstanding = 1'b1;
      lat_left    = int'($urandom_range(1, lat_max));
      rsp_addr    = acc_addr;
      acc_seen    = 1'b0;
    end
    imem_rsp_valid = 1'b0;
    if (outstanding) begin
      lat_left--;
      if (lat_left == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_data(rsp_addr);
        outstanding    = 1'b0;
      end
    end else if (int'($urandom_range(0, 99)) < spur_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
    imem_req_ready = !outstanding && (int'($urandom_range(0, 99)) < rdy_pct);
    inst_ready     = int'($urandom_range(0, 99)) < ir_pct;
    halt           = int'($urandom_range(0, 99)) < halt_pct;
    redirect_valid = 1'b0;
    if (rst && (force_en || int'($urandom_range(0, 99)) < redir_pct)) begin
      tgt            = force_en ? force_tgt : pick_target();
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      seg_q.push_back(tgt & ~64'h3);
    end
  endtask

  // Monitor / scoreboard: samples on the falling edge.
  logic [63:0] exp_pc = '0;
  int          cyc = 0;
  int          hs_count = 0;
  int          zw_first_acc = -1;
  int          zw_last_hs = -1;
  int          zw_acc_n = 0;
  logic        p_rst = 1'b0, p_req_valid = 1'b0, p_req_ready = 1'b0, p_redirect = 1'b0;
  logic        p_inst_valid = 1'b0, p_inst_ready = 1'b0, p_halt = 1'b0;
  logic [63:0] p_req_addr = '0, p_inst_pc = '0;
  logic [31:0] p_inst = '0;

  task automatic pop_segment(input string why);
    if (seg_q.size() == 0) begin
      n_checks++;
      $display("FAIL seg_queue_%s: got empty queue, expected a segment", why);
    end else begin
      exp_pc = seg_q.pop_front();
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      check("rst_req_valid", 64'(imem_req_valid), 64'd0);
      check("rst_inst_valid", 64'(inst_valid), 64'd0);
      check("rst_inst", 64'(inst), 64'd0);
      check("rst_inst_pc", inst_pc, 64'd0);
      acc_seen = 1'b0;
    end else begin
      if (!p_rst) pop_segment("reset");
      if (imem_req_valid) check("req_addr_align", 64'(imem_req_addr[1:0]), 64'd0);
      if (p_rst && p_req_valid && !p_req_ready) begin
        check("req_valid_held", 64'(imem_req_valid), 64'd1);
        check("req_addr_held", imem_req_addr, p_req_addr);
      end
      if (p_rst && p_redirect) begin
        check("flush_after_redirect", 64'(inst_valid), 64'd0);
      end else if (p_rst && p_inst_valid && !p_inst_ready) begin
        check("inst_valid_held", 64'(inst_valid), 64'd1);
        check("inst_held", 64'(inst), 64'(p_inst));
        check("inst_pc_held", inst_pc, p_inst_pc);
      end
      if (p_rst && p_halt && !p_req_valid)
        check("halt_no_new_req", 64'(imem_req_valid), 64'd0);
      if (zw && imem_req_valid && imem_req_ready) begin
        check("zw_req_addr", imem_req_addr, RESET_PC + 64'(4 * zw_acc_n));
        zw_acc_n++;
        if (zw_first_acc < 0) zw_first_acc = cyc;
      end
      if (inst_valid && inst_ready) begin
        check("inst_pc", inst_pc, exp_pc);
        check("inst_data", 64'(inst), 64'(mem_data(exp_pc)));
        exp_pc = exp_pc + 64'd4;
        hs_count++;
        if (zw) begin
          if (zw_last_hs < 0) check("zw_first_latency", 64'(cyc - zw_first_acc), 64'd2);
          else check("zw_inst_gap", 64'(cyc - zw_last_hs), 64'd2);
          zw_last_hs = cyc;
        end
      end
      if (redirect_valid) pop_segment("redirect");
      acc_seen = imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
    end
    p_rst        = rst;
    p_req_valid  = imem_req_valid;
    p_req_ready  = imem_req_ready;
    p_req_addr   = imem_req_addr;
    p_redirect   = redirect_valid;
    p_inst_valid = inst_valid;
    p_inst_ready = inst_ready;
    p_inst       = inst;
    p_inst_pc    = inst_pc;
    p_halt       = halt;
  end

  initial begin
    seg_q.push_back(RESET_PC);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    zw  = 1'b1;
    // Zero-wait memory, decoder always ready.
    for (int c = 0; c < 24; c++) step(100, 1, 100, 0, 0, 0, 0, 1'b0, '0);
    zw = 1'b0;
    // Back-pressure on both sides, redirects, halts and stray responses.
    for (int c = 0; c < 600; c++) step(60, 3, 60, 4, 10, 5, 0, 1'b0, '0);
    // PC wrap at the top of the address space.
    step(100, 1, 100, 0, 0, 0, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    for (int c = 0; c < 20; c++) step(100, 1, 100, 0, 0, 0, 0, 1'b0, '0);
    // Resets landing mid-transaction with late responses.
    for (int c = 0; c < 600; c++) step(60, 4, 70, 3, 8, 5, 2, 1'b0, '0);
    for (int c = 0; c < 40; c++) step(100, 1, 100, 0, 0, 0, 0, 1'b0, '0);
    @(negedge clk);
    check("progress_min_insts", 64'(hs_count >= 100), 64'd1);
    check("seg_queue_drained", 64'(seg_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
